// File: rtl/turn_timer.sv
// Two-player move timer: prescaled seconds countdown with pause, turn hand-over,
// and either per-turn reload or chess-style persistent time banks.
module turn_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_W    = 8,
  parameter int TURN_SEC = 10,
  parameter int WARN_SEC = 3,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             timer_rst,
  input  logic             start,
  input  logic             pause,
  input  logic             turn_done,
  output logic             cur_player,
  output logic [SEC_W-1:0] sec_left,
  output logic             running,
  output logic             warning,
  output logic             expire_pulse,
  output logic             time_expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] TURN_VAL = SEC_W'(TURN_SEC);
  localparam logic [SEC_W-1:0] WARN_VAL = SEC_W'(WARN_SEC);
  localparam logic [SEC_W-1:0] ONE_SEC  = SEC_W'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  logic [1:0]       state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [SEC_W-1:0] bank0, bank0_n, bank1, bank1_n;
  logic [SEC_W-1:0] cur_bank;
  logic             player_n, pulse_n, tick;

  assign cur_bank = cur_player ? bank1 : bank0;
  assign tick     = (presc == PRE_MAX);

  // next-state and datapath update for all four states
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    bank0_n  = bank0;
    bank1_n  = bank1;
    player_n = cur_player;
    pulse_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          presc_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        // a completed move beats both pause and a same-cycle tick
        if (turn_done) begin
          player_n = ~cur_player;
          presc_n  = '0;
          if (MODE == 0) begin
            bank0_n = TURN_VAL;
            bank1_n = TURN_VAL;
          end else begin
            bank0_n = bank0;
            bank1_n = bank1;
          end
          state_n = pause ? PAUSED : RUN;
        end else if (pause) begin
          state_n = PAUSED;
        end else if (tick) begin
          presc_n = '0;
          if (cur_bank != '0) begin
            if (cur_player) begin
              bank1_n = bank1 - ONE_SEC;
            end else begin
              bank0_n = bank0 - ONE_SEC;
            end
          end else begin
            bank0_n = bank0;
          end
          if (cur_bank == ONE_SEC) begin
            state_n = EXPIRED;
            pulse_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      PAUSED: begin
        if (!pause) begin
          state_n = RUN;
        end else begin
          state_n = PAUSED;
        end
      end
      EXPIRED: begin
        if (start) begin
          state_n  = RUN;
          player_n = ~cur_player;
          bank0_n  = TURN_VAL;
          bank1_n  = TURN_VAL;
          presc_n  = '0;
        end else begin
          state_n = EXPIRED;
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (timer_rst) begin
      state        <= IDLE;
      presc        <= '0;
      bank0        <= TURN_VAL;
      bank1        <= TURN_VAL;
      cur_player   <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      bank0        <= bank0_n;
      bank1        <= bank1_n;
      cur_player   <= player_n;
      expire_pulse <= pulse_n;
    end
  end

  assign sec_left    = cur_bank;
  assign running     = (state == RUN);
  assign time_expire = (state == EXPIRED);
  assign warning     = ((state == RUN) || (state == PAUSED)) &&
                       (cur_bank != '0) && (cur_bank <= WARN_VAL);

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer: one per-turn instance and one chess-clock instance.
module tb_turn_timer;

  logic clk = 1'b0;
  logic timer_rst;
  logic start0, pause0, done0, start1, pause1, done1;
  logic       p0, run0, warn0, pulse0, exp0;
  logic       p1, run1, warn1, pulse1, exp1;
  logic [7:0] sec0, sec1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_timer #(.TICK_DIV(4), .SEC_W(8), .TURN_SEC(3), .WARN_SEC(2), .MODE(0)) u0 (
    .clk(clk), .timer_rst(timer_rst), .start(start0), .pause(pause0), .turn_done(done0),
    .cur_player(p0), .sec_left(sec0), .running(run0), .warning(warn0),
    .expire_pulse(pulse0), .time_expire(exp0));

  turn_timer #(.TICK_DIV(4), .SEC_W(8), .TURN_SEC(5), .WARN_SEC(2), .MODE(1)) u1 (
    .clk(clk), .timer_rst(timer_rst), .start(start1), .pause(pause1), .turn_done(done1),
    .cur_player(p1), .sec_left(sec1), .running(run1), .warning(warn1),
    .expire_pulse(pulse1), .time_expire(exp1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    timer_rst = 1'b1;
    start0 = 1'b0; pause0 = 1'b0; done0 = 1'b0;
    start1 = 1'b0; pause1 = 1'b0; done1 = 1'b0;
    step(2);
    chk("rst_running", run0, 1'b0);
    chk("rst_sec", sec0, 8'd3);
    chk("rst_player", p0, 1'b0);
    chk("rst_expire", exp0, 1'b0);
    chk("rst_pulse", pulse0, 1'b0);
    chk("rst_warn", warn0, 1'b0);
    timer_rst = 1'b0;
    step(1);

    // basic countdown to expiry
    start0 = 1'b1; step(1); start0 = 1'b0;
    chk("start_running", run0, 1'b1);
    chk("start_sec", sec0, 8'd3);
    for (int i = 1; i <= 13; i++) begin
      step(1);
      if (i == 3) begin chk("cd_sec_i3", sec0, 8'd3); chk("cd_warn_i3", warn0, 1'b0); end
      if (i == 4) begin chk("cd_sec_i4", sec0, 8'd2); chk("cd_warn_i4", warn0, 1'b1); end
      if (i == 8) begin chk("cd_sec_i8", sec0, 8'd1); chk("cd_warn_i8", warn0, 1'b1); end
      if (i == 11) chk("cd_pulse_i11", pulse0, 1'b0);
      if (i == 12) begin
        chk("cd_pulse_i12", pulse0, 1'b1);
        chk("cd_sec_i12", sec0, 8'd0);
        chk("cd_expire_i12", exp0, 1'b1);
        chk("cd_running_i12", run0, 1'b0);
        chk("cd_warn_i12", warn0, 1'b0);
      end
      if (i == 13) begin chk("cd_pulse_i13", pulse0, 1'b0); chk("cd_expire_i13", exp0, 1'b1); end
    end

    // rearm from EXPIRED, then turn_done mid-count
    start0 = 1'b1; step(1); start0 = 1'b0;
    chk("rearm_running", run0, 1'b1);
    chk("rearm_player", p0, 1'b1);
    chk("rearm_sec", sec0, 8'd3);
    chk("rearm_expire", exp0, 1'b0);
    step(6);
    chk("td_pre_sec", sec0, 8'd2);
    done0 = 1'b1; step(1); done0 = 1'b0;
    chk("td_player", p0, 1'b0);
    chk("td_sec", sec0, 8'd3);
    step(11);
    chk("td_pulse_11", pulse0, 1'b0);
    step(1);
    chk("td_pulse_12", pulse0, 1'b1);

    // turn_done coincident with the final tick
    start0 = 1'b1; step(1); start0 = 1'b0;
    step(8);
    chk("co_sec1", sec0, 8'd1);
    step(3);
    done0 = 1'b1; step(1); done0 = 1'b0;
    chk("co_pulse", pulse0, 1'b0);
    chk("co_expire", exp0, 1'b0);
    chk("co_player", p0, 1'b0);
    chk("co_sec", sec0, 8'd3);
    chk("co_running", run0, 1'b1);

    // pause with prescaler at 2, ignored turn_done, resume
    step(2);
    pause0 = 1'b1; step(1);
    chk("ps_running", run0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      done0 = (i == 5);
      step(1);
    end
    done0 = 1'b0;
    chk("ps_player", p0, 1'b0);
    chk("ps_sec", sec0, 8'd3);
    pause0 = 1'b0; step(1);
    chk("ps_resume_running", run0, 1'b1);
    step(1);
    chk("ps_resume_sec_r1", sec0, 8'd3);
    step(1);
    chk("ps_resume_sec_r2", sec0, 8'd2);

    // reset mid-count on player 1 at one second left
    done0 = 1'b1; step(1); done0 = 1'b0;
    chk("mr_player", p0, 1'b1);
    step(8);
    chk("mr_sec1", sec0, 8'd1);
    step(1);
    timer_rst = 1'b1; step(1); timer_rst = 1'b0;
    chk("mr_running", run0, 1'b0);
    chk("mr_player0", p0, 1'b0);
    chk("mr_sec", sec0, 8'd3);
    chk("mr_warn", warn0, 1'b0);
    chk("mr_expire", exp0, 1'b0);
    chk("mr_pulse", pulse0, 1'b0);

    // chess clock: banks persist across turns
    start1 = 1'b1; step(1); start1 = 1'b0;
    chk("cc_running", run1, 1'b1);
    chk("cc_sec5", sec1, 8'd5);
    step(8);
    chk("cc_p0_burn", sec1, 8'd3);
    done1 = 1'b1; step(1); done1 = 1'b0;
    chk("cc_p1_player", p1, 1'b1);
    chk("cc_p1_sec", sec1, 8'd5);
    step(4);
    chk("cc_p1_burn", sec1, 8'd4);
    done1 = 1'b1; step(1); done1 = 1'b0;
    chk("cc_back_player", p1, 1'b0);
    chk("cc_back_sec", sec1, 8'd3);
    chk("cc_back_warn", warn1, 1'b0);
    step(4);
    chk("cc_warn_sec", sec1, 8'd2);
    chk("cc_warn", warn1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
